// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with valid/ready handshakes on both sides.
// Single-cycle ops finish in one cycle; MUL is an iterative shift-add that stalls upstream.
module alu_exec_stage #(
  parameter int DATA_W  = 32,
  parameter int MUL_BPC = 1
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iValid,
  output logic              oReady,
  input  logic [DATA_W-1:0] iSrcA,
  input  logic [DATA_W-1:0] iSrcB,
  input  logic [3:0]        iAluOp,
  input  logic [4:0]        iRd,
  output logic              oValid,
  input  logic              iReady,
  output logic [DATA_W-1:0] oResult,
  output logic [4:0]        oRd,
  output logic [3:0]        oFlags
);

  localparam int MSB       = DATA_W - 1;
  localparam int SH_W      = $clog2(DATA_W);
  localparam int MUL_STEPS = DATA_W / MUL_BPC;
  localparam int CNT_W     = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_STEPS - 1);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_PASSB = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic              w_is_mul;
  logic              w_mul_last;
  logic [SH_W-1:0]   w_shamt;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_res;
  logic              w_c;
  logic              w_v;
  logic [DATA_W-1:0] w_part;
  logic [DATA_W-1:0] w_acc_nxt;
  logic [DATA_W-1:0] r_mul_a;
  logic [DATA_W-1:0] r_mul_b;
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [4:0]        r_mul_rd;
  logic [DATA_W-1:0] r_result;
  logic [4:0]        r_rd;
  logic [3:0]        r_flags;

  assign w_is_mul   = (iAluOp == OP_MUL);
  assign w_accept   = iValid & oReady;
  assign w_mul_last = (r_cnt == CNT_LAST);
  assign w_shamt    = iSrcB[SH_W-1:0];
  assign w_sum      = {1'b0, iSrcA} + {1'b0, iSrcB};
  // Borrow out of the extended subtraction is the inverse of A >= B unsigned.
  assign w_diff     = {1'b0, iSrcA} - {1'b0, iSrcB};
  assign w_acc_nxt  = r_acc + w_part;

  assign oResult = r_result;
  assign oRd     = r_rd;
  assign oFlags  = r_flags;

  // Single-cycle result and carry/overflow for the presented opcode.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (iAluOp)
      OP_ADD: begin
        w_res = w_sum[MSB:0];
        w_c   = w_sum[DATA_W];
        w_v   = (iSrcA[MSB] == iSrcB[MSB]) && (w_sum[MSB] != iSrcA[MSB]);
      end
      OP_SUB: begin
        w_res = w_diff[MSB:0];
        w_c   = ~w_diff[DATA_W];
        w_v   = (iSrcA[MSB] != iSrcB[MSB]) && (w_diff[MSB] != iSrcA[MSB]);
      end
      OP_AND:   w_res = iSrcA & iSrcB;
      OP_OR:    w_res = iSrcA | iSrcB;
      OP_XOR:   w_res = iSrcA ^ iSrcB;
      OP_SLL:   w_res = iSrcA << w_shamt;
      OP_SRL:   w_res = iSrcA >> w_shamt;
      OP_SRA:   w_res = $unsigned($signed(iSrcA) >>> w_shamt);
      OP_SLT:   w_res = {{(DATA_W-1){1'b0}}, ($signed(iSrcA) < $signed(iSrcB))};
      OP_SLTU:  w_res = {{(DATA_W-1){1'b0}}, (iSrcA < iSrcB)};
      OP_PASSB: w_res = iSrcB;
      default:  w_res = '0;
    endcase
  end

  // Partial product for the MUL_BPC multiplier bits retired this cycle.
  always_comb begin
    w_part = '0;
    for (int j = 0; j < MUL_BPC; j++) begin
      w_part = w_part + ((r_mul_a & {DATA_W{r_mul_b[j]}}) << j);
    end
  end

  // State register.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_is_mul ? S_MUL : S_HOLD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MUL: begin
        if (w_mul_last) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_state_nxt = S_MUL;
        end
      end
      S_HOLD: begin
        if (!iReady) begin
          w_state_nxt = S_HOLD;
        end else if (w_accept) begin
          w_state_nxt = w_is_mul ? S_MUL : S_HOLD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs: ready depends only on state and downstream ready.
  always_comb begin
    oReady = 1'b0;
    oValid = 1'b0;
    case (r_state)
      S_IDLE: oReady = 1'b1;
      S_HOLD: begin
        oReady = iReady;
        oValid = 1'b1;
      end
      default: begin
        oReady = 1'b0;
        oValid = 1'b0;
      end
    endcase
  end

  // Multiplier operands, accumulator and step counter.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_mul_a  <= '0;
      r_mul_b  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_mul_rd <= 5'd0;
    end else if (w_accept && w_is_mul) begin
      r_mul_a  <= iSrcA;
      r_mul_b  <= iSrcB;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_mul_rd <= iRd;
    end else if (r_state == S_MUL) begin
      r_mul_a <= r_mul_a << MUL_BPC;
      r_mul_b <= r_mul_b >> MUL_BPC;
      r_acc   <= w_acc_nxt;
      r_cnt   <= r_cnt + 1'b1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Output register; a held result only changes on accept or MUL completion.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_result <= '0;
      r_rd     <= 5'd0;
      r_flags  <= 4'd0;
    end else if (w_accept && !w_is_mul) begin
      r_result <= w_res;
      r_rd     <= iRd;
      r_flags  <= {(w_res == '0), w_res[MSB], w_c, w_v};
    end else if ((r_state == S_MUL) && w_mul_last) begin
      r_result <= w_acc_nxt;
      r_rd     <= r_mul_rd;
      r_flags  <= {(w_acc_nxt == '0), w_acc_nxt[MSB], 2'b00};
    end else begin
      r_flags <= r_flags;
    end
  end

endmodule
